// File: rtl/vending_fsm_ctrl.sv
// Vending controller: coin credit accumulation, one-hot vend pulse, change handshake, error flags.
// Optional idle auto-cancel in CREDIT is enabled by defining VM_TIMEOUT_EN.
module vending_fsm_ctrl #(
    parameter int unsigned NUM_ITEMS   = 2,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned COIN_W      = 4,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd15, 8'd10},
    parameter int unsigned MAX_CREDIT  = 50,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 CoinValid,
    input  logic [COIN_W-1:0]    CoinValue,
    input  logic [NUM_ITEMS-1:0] Select,
    input  logic                 Cancel,
    input  logic [NUM_ITEMS-1:0] Stock,
    input  logic                 ChangeAck,
    output logic [NUM_ITEMS-1:0] Vend,
    output logic                 CoinReject,
    output logic                 ChangeValid,
    output logic [CREDIT_W-1:0]  ChangeAmt,
    output logic [CREDIT_W-1:0]  Credit,
    output logic                 Error,
    output logic [2:0]           ErrCode,
    output logic                 Busy
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    localparam logic [2:0] ERR_INSUFF   = 3'd1;
    localparam logic [2:0] ERR_SOLDOUT  = 3'd2;
    localparam logic [2:0] ERR_MULTI    = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;
`ifdef VM_TIMEOUT_EN
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    state_t                r_state;
    logic [NUM_ITEMS-1:0]  r_vend;
    logic                  r_coin_reject;
    logic                  r_change_valid;
    logic [CREDIT_W-1:0]   r_change_amt;
    logic [CREDIT_W-1:0]   r_credit;
    logic                  r_error;
    logic [2:0]            r_err_code;
    logic                  r_busy;

    logic [CREDIT_W-1:0]   w_price;
    logic                  w_sel_any;
    logic                  w_sel_multi;
    logic                  w_in_stock;
    logic [SUM_W-1:0]      w_coin_sum;
    logic                  w_coin_fits;
    logic                  w_coin_nonzero;

    // Price of the selected item; only meaningful when Select is one-hot.
    always_comb begin
        w_price = '0;
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            if (Select[i]) begin
                w_price = w_price | PRICE_LIST[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign w_sel_any      = |Select;
    assign w_sel_multi    = (Select & (Select - NUM_ITEMS'(1))) != '0;
    assign w_in_stock     = |(Select & Stock);
    assign w_coin_sum     = {1'b0, r_credit} + SUM_W'(CoinValue);
    assign w_coin_fits    = w_coin_sum <= SUM_W'(MAX_CREDIT);
    assign w_coin_nonzero = CoinValue != '0;

`ifdef VM_TIMEOUT_EN
    logic [TMR_W-1:0] r_timer;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            r_state        <= ST_IDLE;
            r_vend         <= '0;
            r_coin_reject  <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_amt   <= '0;
            r_credit       <= '0;
            r_error        <= 1'b0;
            r_err_code     <= 3'd0;
            r_busy         <= 1'b0;
`ifdef VM_TIMEOUT_EN
            r_timer        <= '0;
`endif
        end else begin
            r_vend        <= '0;
            r_coin_reject <= 1'b0;
            r_error       <= 1'b0;
            r_err_code    <= 3'd0;
`ifdef VM_TIMEOUT_EN
            r_timer       <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_sel_any) begin
                        r_error       <= 1'b1;
                        r_err_code    <= w_sel_multi ? ERR_MULTI : ERR_INSUFF;
                        r_coin_reject <= CoinValid && w_coin_nonzero;
                    end else if (CoinValid && w_coin_nonzero) begin
                        if (w_coin_fits) begin
                            r_credit <= w_coin_sum[CREDIT_W-1:0];
                            r_state  <= ST_CREDIT;
                        end else begin
                            r_coin_reject <= 1'b1;
                            r_error       <= 1'b1;
                            r_err_code    <= ERR_OVERFLOW;
                        end
                    end
                end
                ST_CREDIT: begin
                    // Priority: Cancel > Select > Coin.
                    if (Cancel) begin
                        r_coin_reject  <= CoinValid;
                        r_change_valid <= 1'b1;
                        r_change_amt   <= r_credit;
                        r_busy         <= 1'b1;
                        r_state        <= ST_CHANGE;
                    end else if (w_sel_any) begin
                        r_coin_reject <= CoinValid;
                        if (w_sel_multi) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_MULTI;
                        end else if (!w_in_stock) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_SOLDOUT;
                        end else if (r_credit < w_price) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_INSUFF;
                        end else begin
                            r_vend   <= Select;
                            r_credit <= r_credit - w_price;
                            r_busy   <= 1'b1;
                            r_state  <= ST_VEND;
                        end
                    end else if (CoinValid) begin
                        if (w_coin_fits) begin
                            r_credit <= w_coin_sum[CREDIT_W-1:0];
                        end else begin
                            r_coin_reject <= 1'b1;
                            r_error       <= 1'b1;
                            r_err_code    <= ERR_OVERFLOW;
                        end
`ifdef VM_TIMEOUT_EN
                    end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        r_error        <= 1'b1;
                        r_err_code     <= ERR_TIMEOUT;
                        r_change_valid <= 1'b1;
                        r_change_amt   <= r_credit;
                        r_busy         <= 1'b1;
                        r_state        <= ST_CHANGE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
`endif
                    end
                end
                ST_VEND: begin
                    r_coin_reject <= CoinValid;
                    if (r_credit != '0) begin
                        r_change_valid <= 1'b1;
                        r_change_amt   <= r_credit;
                        r_busy         <= 1'b1;
                        r_state        <= ST_CHANGE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    r_coin_reject <= CoinValid;
                    if (ChangeAck) begin
                        r_credit       <= '0;
                        r_change_valid <= 1'b0;
                        r_change_amt   <= '0;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Vend        = r_vend;
    assign CoinReject  = r_coin_reject;
    assign ChangeValid = r_change_valid;
    assign ChangeAmt   = r_change_amt;
    assign Credit      = r_credit;
    assign Error       = r_error;
    assign ErrCode     = r_err_code;
    assign Busy        = r_busy;

endmodule

// File: tb/tb_vending_fsm_ctrl.sv
// Directed bench for vending_fsm_ctrl; timeout scenario runs when VM_TIMEOUT_EN is defined.
module tb_vending_fsm_ctrl;

    localparam int unsigned TB_TIMEOUT = 8;

    logic       Clk = 1'b0;
    logic       RstN;
    logic       CoinValid;
    logic [3:0] CoinValue;
    logic [1:0] Select;
    logic       Cancel;
    logic [1:0] Stock;
    logic       ChangeAck;
    logic [1:0] Vend;
    logic       CoinReject;
    logic       ChangeValid;
    logic [7:0] ChangeAmt;
    logic [7:0] Credit;
    logic       Error;
    logic [2:0] ErrCode;
    logic       Busy;

    int n_checks = 0;
    int n_errors = 0;

    vending_fsm_ctrl #(
        .NUM_ITEMS  (2),
        .CREDIT_W   (8),
        .COIN_W     (4),
        .PRICE_LIST ({8'd15, 8'd10}),
        .MAX_CREDIT (50),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .Clk(Clk), .RstN(RstN), .CoinValid(CoinValid), .CoinValue(CoinValue),
        .Select(Select), .Cancel(Cancel), .Stock(Stock), .ChangeAck(ChangeAck),
        .Vend(Vend), .CoinReject(CoinReject), .ChangeValid(ChangeValid),
        .ChangeAmt(ChangeAmt), .Credit(Credit), .Error(Error), .ErrCode(ErrCode),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Observed outputs in one vector: Vend, CoinReject, ChangeValid, ChangeAmt, Credit, Error, ErrCode, Busy.
    logic [24:0] w_all;
    assign w_all = {Vend, CoinReject, ChangeValid, ChangeAmt, Credit, Error, ErrCode, Busy};

    function automatic logic [24:0] pack(input logic [1:0] vend, input logic rej, input logic cv,
                                         input logic [7:0] amt, input logic [7:0] cr,
                                         input logic err, input logic [2:0] code, input logic busy);
        return {vend, rej, cv, amt, cr, err, code, busy};
    endfunction

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic coin(input logic [3:0] v);
        CoinValid = 1'b1;
        CoinValue = v;
        cycle();
        CoinValid = 1'b0;
        CoinValue = 4'd0;
    endtask

    task automatic test_reset();
        logic [24:0] e;
        RstN = 1'b0; CoinValid = 1'b0; CoinValue = 4'd0; Select = 2'b00;
        Cancel = 1'b0; Stock = 2'b11; ChangeAck = 1'b0;
        cycle(); cycle();
        e = pack(2'b00, 0, 0, 8'd0, 8'd0, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL reset_state: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        RstN = 1'b1;
        cycle();
    endtask

    task automatic test_vend_exact();
        logic [24:0] e;
        coin(4'd5);
        coin(4'd5);
        e = pack(2'b00, 0, 0, 8'd0, 8'd10, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL exact_credit10: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        Select = 2'b01; cycle(); Select = 2'b00;
        e = pack(2'b01, 0, 0, 8'd0, 8'd0, 0, 3'd0, 1);
        if (w_all !== e) begin $display("FAIL exact_vend: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        cycle();
        e = pack(2'b00, 0, 0, 8'd0, 8'd0, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL exact_idle: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
    endtask

    task automatic test_vend_change();
        logic [24:0] e;
        coin(4'd5); coin(4'd5); coin(4'd5); coin(4'd4);
        if (Credit !== 8'd19) begin $display("FAIL change_credit19: got %0d expected 19", Credit); n_errors++; end
        n_checks++;
        Select = 2'b10; cycle(); Select = 2'b00;
        e = pack(2'b10, 0, 0, 8'd0, 8'd4, 0, 3'd0, 1);
        if (w_all !== e) begin $display("FAIL change_vend: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        cycle();
        e = pack(2'b00, 0, 1, 8'd4, 8'd4, 0, 3'd0, 1);
        if (w_all !== e) begin $display("FAIL change_pending: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        cycle();
        if (w_all !== e) begin $display("FAIL change_held: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
        e = pack(2'b00, 0, 0, 8'd0, 8'd0, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL change_acked: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
    endtask

    task automatic test_errors();
        logic [24:0] e;
        Select = 2'b01; cycle(); Select = 2'b00;
        e = pack(2'b00, 0, 0, 8'd0, 8'd0, 1, 3'd1, 0);
        if (w_all !== e) begin $display("FAIL err_idle_insuff: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        coin(4'd5);
        Select = 2'b01; cycle(); Select = 2'b00;
        e = pack(2'b00, 0, 0, 8'd0, 8'd5, 1, 3'd1, 0);
        if (w_all !== e) begin $display("FAIL err_insuff: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        cycle();
        e = pack(2'b00, 0, 0, 8'd0, 8'd5, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL err_pulse_drop: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        Select = 2'b11; cycle(); Select = 2'b00;
        e = pack(2'b00, 0, 0, 8'd0, 8'd5, 1, 3'd3, 0);
        if (w_all !== e) begin $display("FAIL err_multi: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        coin(4'd5);
        Stock = 2'b10; Select = 2'b01; cycle(); Select = 2'b00; Stock = 2'b11;
        e = pack(2'b00, 0, 0, 8'd0, 8'd10, 1, 3'd2, 0);
        if (w_all !== e) begin $display("FAIL err_soldout: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        Cancel = 1'b1; cycle(); Cancel = 1'b0;
        e = pack(2'b00, 0, 1, 8'd10, 8'd10, 0, 3'd0, 1);
        if (w_all !== e) begin $display("FAIL err_cancel: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
    endtask

    task automatic test_overflow();
        logic [24:0] e;
        coin(4'd15); coin(4'd15); coin(4'd15); coin(4'd3);
        coin(4'd5);
        e = pack(2'b00, 1, 0, 8'd0, 8'd48, 1, 3'd4, 0);
        if (w_all !== e) begin $display("FAIL ovf_reject: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        CoinValid = 1'b1; CoinValue = 4'd3; Cancel = 1'b1;
        cycle();
        CoinValid = 1'b0; CoinValue = 4'd0; Cancel = 1'b0;
        e = pack(2'b00, 1, 1, 8'd48, 8'd48, 0, 3'd0, 1);
        if (w_all !== e) begin $display("FAIL ovf_coin_cancel: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
        coin(4'd15); coin(4'd15); coin(4'd15); coin(4'd5);
        e = pack(2'b00, 0, 0, 8'd0, 8'd50, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL ovf_exact_max: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        coin(4'd1);
        e = pack(2'b00, 1, 0, 8'd0, 8'd50, 1, 3'd4, 0);
        if (w_all !== e) begin $display("FAIL ovf_max_plus1: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        Cancel = 1'b1; cycle(); Cancel = 1'b0;
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
    endtask

    task automatic test_reset_in_change();
        logic [24:0] e;
        coin(4'd5); coin(4'd5);
        Cancel = 1'b1; cycle(); Cancel = 1'b0;
        e = pack(2'b00, 0, 1, 8'd10, 8'd10, 0, 3'd0, 1);
        if (w_all !== e) begin $display("FAIL rst_pre_change: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        RstN = 1'b0; cycle(); RstN = 1'b1;
        e = pack(2'b00, 0, 0, 8'd0, 8'd0, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL rst_in_change: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
        if (w_all !== e) begin $display("FAIL rst_change_lost: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
    endtask

    task automatic test_busy_ignore();
        logic [24:0] e;
        coin(4'd0);
        Cancel = 1'b1; cycle(); Cancel = 1'b0;
        e = pack(2'b00, 0, 0, 8'd0, 8'd0, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL idle_zero_coin_cancel: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        coin(4'd15); coin(4'd5);
        Select = 2'b10; cycle(); Select = 2'b00;
        CoinValid = 1'b1; CoinValue = 4'd5; Cancel = 1'b1;
        cycle();
        CoinValid = 1'b0; CoinValue = 4'd0; Cancel = 1'b0;
        e = pack(2'b00, 1, 1, 8'd5, 8'd5, 0, 3'd0, 1);
        if (w_all !== e) begin $display("FAIL busy_vend_coin: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        CoinValid = 1'b1; CoinValue = 4'd5; Select = 2'b01;
        cycle();
        CoinValid = 1'b0; CoinValue = 4'd0; Select = 2'b00;
        if (w_all !== e) begin $display("FAIL busy_change_ignore: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
        // Back-to-back: a coin right after returning to IDLE is accepted.
        coin(4'd7);
        e = pack(2'b00, 0, 0, 8'd0, 8'd7, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL back_to_back_coin: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        Cancel = 1'b1; cycle(); Cancel = 1'b0;
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
    endtask

    task automatic test_timeout();
        logic [24:0] e;
        coin(4'd7);
`ifdef VM_TIMEOUT_EN
        repeat (TB_TIMEOUT - 1) cycle();
        e = pack(2'b00, 0, 0, 8'd0, 8'd7, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL timeout_early: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        cycle();
        e = pack(2'b00, 0, 1, 8'd7, 8'd7, 1, 3'd5, 1);
        if (w_all !== e) begin $display("FAIL timeout_fire: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
`else
        repeat (3 * TB_TIMEOUT) cycle();
        e = pack(2'b00, 0, 0, 8'd0, 8'd7, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL no_timeout_hold: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
        Cancel = 1'b1; cycle(); Cancel = 1'b0;
`endif
        ChangeAck = 1'b1; cycle(); ChangeAck = 1'b0;
        e = pack(2'b00, 0, 0, 8'd0, 8'd0, 0, 3'd0, 0);
        if (w_all !== e) begin $display("FAIL timeout_cleanup: got %h expected %h", w_all, e); n_errors++; end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_errors();
        test_overflow();
        test_reset_in_change();
        test_busy_ignore();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
